// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: access size encodings, funct3 decode and the data-memory
// responder FSM state type.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // LB/LH/LW/LBU/LHU/SB/SH/SW: funct3[1:0] is the size, funct3[2] selects zero-extension.
  function automatic logic [1:0] funct3_to_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic funct3_is_unsigned(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for a 32-bit data port: store byte enables and data replication,
// load lane extraction with sign/zero extension.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    unique case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    rbyte     = rword[8*addr_lo +: 8];
    rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
    rdata_ext = '0;
    unique case (size)
      SZ_BYTE: rdata_ext = {{24{rbyte[7] & ~is_unsigned}}, rbyte};
      SZ_HALF: rdata_ext = {{16{rhalf[15] & ~is_unsigned}}, rhalf};
      SZ_WORD: rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with configurable wait states, RV32
// lane handling and fault reporting for misaligned, out-of-range and illegal-size accesses.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AddrW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        started_q, started_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AddrW-1:0] mem_idx;
  logic [31:0]      rword;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic             accept;
  logic             misaligned;
  logic             out_of_range;
  logic             fault;
  logic             mem_we;

  assign mem_idx = req_addr[AddrW+1:2];

  // Out-of-range indices never reach storage: the fault masks both the read and the write.
  assign out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign rword        = out_of_range ? '0 : mem_q[mem_idx];

  always_comb begin
    misaligned = 1'b0;
    if (req_size == SZ_HALF) misaligned = req_addr[0];
    if (req_size == SZ_WORD) misaligned = (req_addr[1:0] != 2'b00);
  end

  assign fault  = misaligned || out_of_range || (req_size == 2'b11);
  assign accept = req_valid && req_ready;
  assign mem_we = accept && req_write && !fault;

  dmem_lane_align u_lane_align (
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    started_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = fault;
          rdata_d = (fault || req_write) ? '0 : rdata_ext;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // started_q holds req_ready low until the first edge after reset release.
  assign req_ready = (state_q == StIdle) && started_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      started_q <= started_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboarded load/store transactions, faults,
// response backpressure and reset during an outstanding request.
module tb_dmem_responder;

  localparam int Wc    = 2;
  localparam int Depth = 256;
  localparam int Bound = 50;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int   errors;
  int   checks;
  exp_t sb_q[$];

  dmem_responder #(
    .DEPTH_WORDS (Depth),
    .WAIT_CYCLES (Wc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: push the expectation, wait for accept, then pop and compare on response.
  task automatic txn(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err, input int stall);
    exp_t        e;
    exp_t        got;
    int          n;
    logic        seen;
    logic [31:0] hold_rdata;
    logic        hold_err;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    rsp_ready    = (stall == 0);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    n = 0;
    while (!req_ready && n < Bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s accept: req_ready=%0b after %0d cycles, required 1", name, req_ready, n);
      void'(sb_q.pop_front());
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < Bound) begin
      @(negedge clk);
      n++;
      seen = rsp_valid;
    end
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != Wc + 1) begin
      errors++;
      $display("FAIL %s latency: rsp_valid after %0d negedges (seen=%0b), required %0d",
               name, n, seen, Wc + 1);
      if (!seen) return;
    end
    got = '{rdata: rsp_rdata, err: rsp_err};
    checks++;
    if (got.rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %08h, required %08h", name, got.rdata, e.rdata);
    end
    checks++;
    if (got.err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %0b, required %0b", name, got.err, e.err);
    end
    hold_rdata = rsp_rdata;
    hold_err   = rsp_err;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== hold_rdata ||
          rsp_err !== hold_err) begin
        errors++;
        $display("FAIL %s stall%0d: valid=%0b ready=%0b rdata=%08h err=%0b, required 1 0 %08h %0b",
                 name, k, rsp_valid, req_ready, rsp_rdata, rsp_err, hold_rdata, hold_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: valid=%0b ready=%0b rdata=%08h err=%0b, required 0 1 0 0",
               name, rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%0b valid=%0b, required 0 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%0b before first edge, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%0b valid=%0b, required 1 0", req_ready, rsp_valid);
    end
    txn("reset_load", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_word();
    txn("st_word", 1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
    txn("ld_word", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);
  endtask

  task automatic test_subword();
    txn("st_byte", 1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    txn("ld_merged", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, 0);
    txn("ld_byte_s", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 0);
    txn("ld_byte_u", 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);
    txn("ld_half_s", 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'hFFFFDEAD, 1'b0, 0);
    txn("ld_half_u", 1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h000080EF, 1'b0, 0);
    txn("st_half", 1'b1, 32'h26, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b0, 0);
    txn("ld_half_w", 1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 32'h12340000, 1'b0, 0);
  endtask

  task automatic test_faults();
    txn("st_misal", 1'b1, 32'h22, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b1, 0);
    txn("ld_unchanged", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, 0);
    txn("ld_half_misal", 1'b0, 32'h23, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 0);
    txn("ld_oob", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
    txn("st_oob", 1'b1, 32'h420, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b1, 0);
    txn("ld_alias", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, 0);
    txn("ld_size11", 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
    txn("ld_last", 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    txn("bp_load", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, 5);
    txn("bp_err", 1'b0, 32'h21, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 5);
  endtask

  task automatic test_reset_mid_op();
    int hits;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h20;
    req_size  = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: valid=%0b ready=%0b, required 0 0", rsp_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL midrst_noresp: rsp_valid seen %0d cycles, required 0", hits);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: req_ready=%0b, required 1", req_ready);
    end
    txn("midrst_cleared", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_backpressure();
    test_reset_mid_op();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake.
- It applies a configurable number of wait states, then returns read data or a write acknowledge over a second valid/ready handshake.
- It performs RV32 byte/half/word lane selection and sign/zero extension, and flags misaligned and out-of-range accesses.
- Position: between the core's load/store unit (initiator) and the data storage. It replaces the zero-latency data memory path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; byte address range is 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, idle cycles between request acceptance and response valid; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  access faulted (misaligned, out of range, or size 11).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port rst.
- While rst=0:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All storage words are cleared to 0.
  - req_ready rises on the first clk edge after rst deasserts.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T, the request is accepted and evaluated at that edge.
  - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; go to RESP when the counter is 0.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge go to IDLE, drop rsp_valid, and clear rsp_rdata and rsp_err.
  - Stalling indefinitely is legal.
- Latency: for an accept at edge T, rsp_valid is high in the cycle after edge T+WAIT_CYCLES. Minimum is 1 cycle with zero backpressure.
- Throughput: one outstanding request. req_ready is low from the accept edge until the response handshake completes. Back-to-back accept is not possible in the same cycle as a response handshake.
- Fault checks at acceptance:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - out of range: addr >= 4*DEPTH_WORDS;
  - size = 11.
  - A faulting store does not modify storage. Any fault gives rsp_err=1 and rsp_rdata=0.
- Stores: committed at the accept edge. Byte enables are derived from size and addr[1:0]; the byte lane is addr[1:0] and the half lane is addr[1]. Unselected bytes are unchanged. Response is rsp_err=0, rsp_rdata=0.
- Loads: the word at index addr[31:2] is read at the accept edge. The lane is extracted, extended per req_unsigned, and registered. Word loads ignore req_unsigned.
- Ordering: a load accepted after a store's response sees the stored data, because the store commits before the response.
- Requests with req_valid=1 while req_ready=0 are ignored. The initiator must hold them.
- Reset mid-operation (WAIT or RESP): the transaction is dropped with no response. An already-committed store is erased, since reset clears storage.

Decomposition:
- Shared package (riscv_pkg):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state typedef {IDLE, WAIT, RESP}.
  - Reuse the funct3-to-size mapping already used by the main control unit.
- One natural sub-module: dmem_lane_align. It is combinational and holds the byte-enable generation, store data replication, and load extract/extend, so it can be unit-tested on its own.
- Storage and FSM stay in dmem_responder.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: req_ready=1 one edge later, rsp_valid=0, and a word load of addr 0x10 returns 0x00000000, err=0.
- Word store/load, WAIT_CYCLES=2: store 0xDEADBEEF to 0x20, then load 0x20. Required: each rsp_valid appears 3 cycles after accept; load rdata=0xDEADBEEF.
- Sub-word: after the previous store, store byte 0x80 to 0x21.
  - Word load of 0x20 returns 0xDEAD80EF.
  - Signed byte load of 0x21 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Signed half load of 0x22 returns 0xFFFFDEAD.
- Faults:
  - Word store to 0x22 gives err=1 and memory is unchanged.
  - Half load from 0x23 gives err=1, rdata=0.
  - Load from 4*DEPTH_WORDS (0x400) gives err=1.
  - size=11 gives err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid, rdata, and err are stable and req_ready=0 throughout; the handshake on cycle 6 returns to IDLE.
- Reset mid-operation: assert rst during WAIT of a load. Required: rsp_valid=0 immediately (asynchronous), no response is ever produced, and the FSM restarts in IDLE.
